// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM state
// encodings, datapath select codes and the control-word layout.
package mc_defs_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StWbMem   = 4'd4,
        StMemWr   = 4'd5,
        StExecI   = 4'd6,
        StWbAlu   = 4'd7,
        StBranch  = 4'd8,
        StHalt    = 4'd9
    } state_e;

    localparam logic [1:0] ALUSRC_A_PC    = 2'b00;
    localparam logic [1:0] ALUSRC_A_RS1   = 2'b01;
    localparam logic [1:0] ALUSRC_A_OLDPC = 2'b10;

    localparam logic [1:0] ALUSRC_B_RS2  = 2'b00;
    localparam logic [1:0] ALUSRC_B_FOUR = 2'b01;
    localparam logic [1:0] ALUSRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // fetch_ld/br_ld/done_rdy are qualified in the top by mem_ready or the branch test.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       wb_sel;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_type;
        logic       fetch_ld;
        logic       br_ld;
        logic       done;
        logic       done_rdy;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// State to control-word ROM for the multicycle control unit.
module mc_output_decode
    import mc_defs_pkg::*;
(
    input  state_e state_i,
    input  logic   is_store_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_a = ALUSRC_A_PC;
                ctrl_o.alu_src_b = ALUSRC_B_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.fetch_ld  = 1'b1;
            end
            StDecode: begin
                // ALUOut captures old_pc + B-immediate as the branch target.
                ctrl_o.alu_src_a = ALUSRC_A_OLDPC;
                ctrl_o.alu_src_b = ALUSRC_B_IMM;
                ctrl_o.imm_type  = IMM_B;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            StMemAddr: begin
                ctrl_o.alu_src_a = ALUSRC_A_RS1;
                ctrl_o.alu_src_b = ALUSRC_B_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.imm_type  = is_store_i ? IMM_S : IMM_I;
            end
            StMemRd: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            StWbMem: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.done_rdy  = 1'b1;
            end
            StExecI: begin
                ctrl_o.alu_src_a = ALUSRC_A_RS1;
                ctrl_o.alu_src_b = ALUSRC_B_IMM;
                ctrl_o.imm_type  = IMM_I;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            StWbAlu: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = 1'b0;
                ctrl_o.done      = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a = ALUSRC_A_RS1;
                ctrl_o.alu_src_b = ALUSRC_B_RS2;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = 1'b1;
                ctrl_o.br_ld     = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for lw/sw/addi/beq/bne: state register, next-state
// logic, sticky illegal flag and retired-instruction counter.
module multicycle_control_unit
    import mc_defs_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter logic [3:0]  RESET_STATE = 4'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic                   alu_zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   ir_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   i_or_d,
    output logic                   reg_write,
    output logic                   wb_sel,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             imm_type,
    output logic                   instr_done,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] retired,
    output logic [3:0]             state
);

    state_e                 state_q, state_d;
    logic                   illegal_q;
    logic [COUNT_WIDTH-1:0] retired_q;
    ctrl_t                  ctrl;
    logic                   is_store;
    logic                   en;

    assign is_store = (opcode == OP_STORE);

    mc_output_decode u_decode (
        .state_i    (state_q),
        .is_store_i (is_store),
        .ctrl_o     (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = StMemAddr;
                    OP_IMM:            state_d = StExecI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? StBranch : StHalt;
                    default:           state_d = StHalt;
                endcase
            end
            StMemAddr: state_d = is_store ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) state_d = StWbMem;
            StWbMem:   state_d = StFetch;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StExecI:   state_d = StWbAlu;
            StWbAlu:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StHalt;
        endcase
    end

    // Strobes are forced low while reset is held so an abandoned access stops at once.
    assign en         = ~reset;
    assign mem_read   = ctrl.mem_read & en;
    assign mem_write  = ctrl.mem_write & en;
    assign reg_write  = ctrl.reg_write & en;
    assign ir_write   = ctrl.fetch_ld & mem_ready & en;
    assign pc_write   = ((ctrl.fetch_ld & mem_ready) |
                         (ctrl.br_ld & (alu_zero ^ funct3[0]))) & en;
    assign instr_done = (ctrl.done | (ctrl.done_rdy & mem_ready)) & en;
    assign pc_src     = ctrl.pc_src;
    assign i_or_d     = ctrl.i_or_d;
    assign wb_sel     = ctrl.wb_sel;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign imm_type   = ctrl.imm_type;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= state_e'(RESET_STATE);
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + COUNT_WIDTH'(1);
            end
            if (state_d == StHalt) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign illegal = illegal_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule
